// File: rtl/paddle_ai.sv
// paddle_ai: rate-limited, delayed computer opponent driving the right paddle centre (p2_y).
// Optional aim error: define PADDLE_AI_MISS_EN to add an LFSR-driven offset to the TRACK target.
//
// state  | meaning
// IDLE   | AI disabled, paddle parked at CENTER
// CENTER | drift back to CENTER, wait for the ball to approach
// REACT  | ball approaching, hold still for REACT_TICKS ticks
// TRACK  | follow ball y with deadzone and step limit
module paddle_ai #(
    parameter int SCREEN_H    = 480,
    parameter int CENTER      = 240,
    parameter int HALF_BIG    = 40,
    parameter int HALF_SMALL  = 24,
    parameter int TICK_DIV    = 250000,
    parameter int REACT_TICKS = 8,
    parameter int DEADZONE    = 4,
    parameter int STEP_SLOW   = 2,
    parameter int STEP_FAST   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [10:0] bx,
    input  logic [10:0] by,
    input  logic        hit,
    input  logic        goal,
    input  logic        bat_size,
    input  logic        ball_speed,
    output logic [10:0] p_y,
    output logic [1:0]  ai_state,
    output logic        moving
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = (REACT_TICKS > 1) ? $clog2(REACT_TICKS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CENTER = 2'd1,
        ST_REACT  = 2'd2,
        ST_TRACK  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [10:0]   bx_prev;
    logic          dir_app;
    logic          app_now;
    logic [RW-1:0] react_cnt, react_nx;

    logic signed [11:0] cur, tgt, p_nx;
    logic signed [11:0] lo_lim, hi_lim, step_sz;
    logic signed [11:0] dz_d, dz_abs;

    function automatic logic signed [11:0] clamp12(input logic signed [12:0] v,
                                                  input logic signed [11:0] lo,
                                                  input logic signed [11:0] hi);
        logic signed [12:0] lo13;
        logic signed [12:0] hi13;
        lo13 = lo;
        hi13 = hi;
        if (v < lo13)      return lo;
        else if (v > hi13) return hi;
        else               return v[11:0];
    endfunction

    // Moves at most one step toward target; lands exactly on it when closer than a step.
    function automatic logic signed [11:0] step_toward(input logic signed [11:0] from,
                                                      input logic signed [11:0] to,
                                                      input logic signed [11:0] stp);
        logic signed [11:0] d;
        d = to - from;
        if (d >= 12'sd0) return (d < stp) ? to : from + stp;
        else             return (-d < stp) ? to : from - stp;
    endfunction

    assign tick = (tick_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // Equal x positions keep the previously seen direction.
    always_comb begin
        app_now = dir_app;
        if (bx > bx_prev)      app_now = 1'b1;
        else if (bx < bx_prev) app_now = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bx_prev <= '0;
            dir_app <= 1'b0;
        end else if (tick) begin
            bx_prev <= bx;
            dir_app <= app_now;
        end
    end

    assign cur     = $signed({1'b0, p_y});
    assign lo_lim  = bat_size ? 12'(HALF_SMALL) : 12'(HALF_BIG);
    assign hi_lim  = 12'(SCREEN_H - 1) - lo_lim;
    assign step_sz = ball_speed ? 12'(STEP_FAST) : 12'(STEP_SLOW);

`ifdef PADDLE_AI_MISS_EN
    logic [15:0]        lfsr;
    logic signed [11:0] offset;
    logic               enter_track;

    assign enter_track = (state_nx == ST_TRACK) && (state != ST_TRACK);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr   <= 16'hACE1;
            offset <= '0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (enter_track)
                offset <= $signed({{6{lfsr[2]}}, lfsr[2:0], 3'b000});
        end
    end

    assign tgt = clamp12($signed({2'b00, by}) + $signed({offset[11], offset}), lo_lim, hi_lim);
`else
    assign tgt = $signed({1'b0, by});
`endif

    assign dz_d   = tgt - cur;
    assign dz_abs = dz_d[11] ? -dz_d : dz_d;

    always_comb begin
        state_nx = state;
        p_nx     = cur;
        react_nx = react_cnt;
        if (!en) begin
            state_nx = ST_IDLE;
            p_nx     = 12'(CENTER);
            react_nx = '0;
        end else if (state == ST_IDLE) begin
            state_nx = ST_CENTER;
            p_nx     = 12'(CENTER);
        end else begin
            // hit/goal outrank a coincident tick: recentre with no step this cycle
            if (hit || goal) begin
                state_nx = ST_CENTER;
            end else if (tick) begin
                case (state)
                    ST_CENTER: begin
                        p_nx = step_toward(cur, 12'(CENTER), step_sz);
                        if (app_now) begin
                            state_nx = ST_REACT;
                            react_nx = '0;
                        end
                    end
                    ST_REACT: begin
                        if (!app_now)
                            state_nx = ST_CENTER;
                        else if (react_cnt == RW'(REACT_TICKS - 1))
                            state_nx = ST_TRACK;
                        else
                            react_nx = react_cnt + 1'b1;
                    end
                    ST_TRACK: begin
                        if (dz_abs > 12'(DEADZONE))
                            p_nx = step_toward(cur, tgt, step_sz);
                        if (!app_now)
                            state_nx = ST_CENTER;
                    end
                    default: ;
                endcase
            end
            // also pulls p_y back in range when bat_size grows between ticks
            p_nx = clamp12({p_nx[11], p_nx}, lo_lim, hi_lim);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            p_y       <= 11'(CENTER);
            moving    <= 1'b0;
            react_cnt <= '0;
        end else begin
            state     <= state_nx;
            p_y       <= p_nx[10:0];
            moving    <= (p_nx[10:0] != p_y);
            react_cnt <= react_nx;
        end
    end

    assign ai_state = state;

endmodule

// File: tb/tb_paddle_ai.sv
// Scoreboard bench for paddle_ai with TICK_DIV=4: expected moves and state snapshots are
// queued by the stimulus and popped by a negedge monitor.
`timescale 1ns/1ps
module tb_paddle_ai;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [10:0] bx;
    logic [10:0] by;
    logic        hit;
    logic        goal;
    logic        bat_size;
    logic        ball_speed;
    logic [10:0] p_y;
    logic [1:0]  ai_state;
    logic        moving;

    typedef struct {
        string name;
        int    py;
        int    st;
        int    mv;
    } snap_t;

    snap_t snap_q[$];
    int    move_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    bx_dir = 0;

    paddle_ai #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bx         (bx),
        .by         (by),
        .hit        (hit),
        .goal       (goal),
        .bat_size   (bat_size),
        .ball_speed (ball_speed),
        .p_y        (p_y),
        .ai_state   (ai_state),
        .moving     (moving)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", n, act, exp, $time);
        end
    endtask

    task automatic snap(input string n, input int py, input int st, input int mv);
        snap_t s;
        s.name = n;
        s.py   = py;
        s.st   = st;
        s.mv   = mv;
        snap_q.push_back(s);
    endtask

    task automatic push_ramp(input int from, input int stp, input int n);
        for (int k = 1; k <= n; k++) move_q.push_back(from + stp * k);
    endtask

    // cyc counts posedges since reset release; ticks land on multiples of 4
    task automatic adv_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
            cyc++;
            bx = 11'(int'(bx) + bx_dir);
        end
    endtask

    always @(negedge clk) begin
        snap_t s;
        if (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            cmp({s.name, ".p_y"}, int'(p_y), s.py);
            cmp({s.name, ".ai_state"}, int'(ai_state), s.st);
            cmp({s.name, ".moving"}, int'(moving), s.mv);
        end
        if (!rst && moving) begin
            if (move_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL move_unexpected p_y=%0d expected no movement (t=%0t)", p_y, $time);
            end else begin
                cmp("move.p_y", int'(p_y), move_q.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b1; bx = 11'd100; by = 11'd400;
        hit = 1'b0; goal = 1'b0; bat_size = 1'b0; ball_speed = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        snap("reset", 240, 0, 0);
        rst = 1'b0;
        bx_dir = 1;

        adv_to(1);    snap("en_rise", 240, 1, 0);
        adv_to(3);    snap("pre_tick", 240, 1, 0);
        adv_to(4);    snap("first_tick", 240, 2, 0);
        adv_to(35);   snap("react_hold", 240, 2, 0);
        adv_to(36);   snap("to_track", 240, 3, 0);
        push_ramp(240, 2, 78);
        adv_to(348);  snap("track_end", 396, 3, 1);
        adv_to(356);  snap("deadzone", 396, 3, 0);

        // ball recedes, fast speed: recentre by 3 per tick
        bx_dir = -1;
        ball_speed = 1'b1;
        push_ramp(396, -3, 52);
        adv_to(360);  snap("recede", 396, 1, 0);
        adv_to(568);  snap("center_reach", 240, 1, 1);
        adv_to(576);  snap("center_rest", 240, 1, 0);

        // approach again toward by=470 with the small bat
        bx_dir = 1;
        ball_speed = 1'b0;
        bat_size = 1'b1;
        by = 11'd470;
        adv_to(580);  snap("react2", 240, 2, 0);
        adv_to(612);  snap("retrack", 240, 3, 0);
        adv_to(615);
        goal = 1'b1;
        adv_to(616);
        goal = 1'b0;
        snap("goal_tick", 240, 1, 0);
        adv_to(652);  snap("track3", 240, 3, 0);
        push_ramp(240, 2, 107);
        move_q.push_back(455);
        adv_to(1092); snap("clamp_small", 455, 3, 0);

        bat_size = 1'b0;
        move_q.push_back(439);
        adv_to(1093); snap("bat_grow", 439, 3, 1);
        adv_to(1100); snap("big_hold", 439, 3, 0);

        en = 1'b0;
        move_q.push_back(240);
        adv_to(1101); snap("en_drop", 240, 0, 1);
        en = 1'b1;
        adv_to(1102); snap("en_back", 240, 1, 0);
        adv_to(1104); snap("react4", 240, 2, 0);
        hit = 1'b1;
        adv_to(1105);
        hit = 1'b0;
        snap("hit", 240, 1, 0);

        adv_to(1108);
        @(negedge clk);
        #1;
        cmp("moves_left", move_q.size(), 0);
        cmp("snaps_left", snap_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
